point_clip_pipe: RTL
====================

// Module: point_clip_pipe
// PURPOSE
//   Parametrised, 2-stage pipelined validity filter for projected maze points (x,y,z + pixel tag p).
//   Rejects points outside the vertical window, behind the viewer, beyond the cell grid, or in a cell
//   whose wall bit is clear; narrows surviving coordinates to OUT_W. Adds valid/ready backpressure,
//   optional drop-on-reject and saturating accept/reject counters. Sits between projection and raster.
// PARAMETERS
//   IN_W         12   signed input coordinate width
//   OUT_W        10   signed output coordinate width (OUT_W <= IN_W)
//   P_W          10   pixel tag width
//   CELL_SH      6    log2 cell size; cell index = x >>> CELL_SH
//   NCELL        5    number of cells / wall bits
//   Y_MAX        64   largest accepted y (inclusive)
//   DROP_INVALID 0    0: emit rejects with out_en=0; 1: rejects removed from stream
//   CNT_W        16   statistics counter width
// PORTS
//   clk        in   1        clock, all state on rising edge
//   rst        in   1        asynchronous, active-high reset
//   wall       in   NCELL    wall-present mask, sampled with the accepted input point
//   in_valid   in   1        input point valid
//   in_ready   out  1        block accepts input this cycle
//   in_x/y/z   in   IN_W     signed input coordinates
//   in_p       in   P_W      pixel tag
//   out_valid  out  1        output beat valid
//   out_ready  in   1        downstream accepts output
//   out_en     out  1        1 = point passed all checks
//   out_x/y/z  out  OUT_W    narrowed coordinates
//   out_p      out  P_W      pixel tag
//   cnt_clr    in   1        synchronous clear of both counters
//   acc_cnt    out  CNT_W    points passed (saturating)
//   rej_cnt    out  CNT_W    points rejected (saturating)
// BEHAVIOUR
//   Reset (async): s1/s2 valid=0, out_valid=0, out_en=0, out_x/y/z/p all-ones, counters 0.
//   Advance: adv = !out_valid | out_ready; in_ready = adv (combinational). Both stages move on adv;
//     when !adv all stage registers, including outputs, hold unchanged.
//   Stage 1 (load when adv & in_valid, else s1_valid<=0 on adv): register point, tag and
//     pass = (y>=0) & (y<=Y_MAX) & (x>=0) & (cidx<NCELL) & wall[cidx]; cidx = x[IN_W-2:CELL_SH].
//     Out-of-range cidx must not index wall (no X propagation).
//   Stage 2 (on adv): pass=1 -> out_en=1, out_c = {c[IN_W-1], c[OUT_W-2:0]} for x,y,z, out_p=p.
//     pass=0 -> out_en=0, out_x/y/z/p all-ones; out_valid = s1_valid when DROP_INVALID=0,
//     s1_valid & pass when DROP_INVALID=1 (reject becomes bubble).
//   Latency: 2 cycles in_valid&in_ready -> out_valid with no stall; throughput 1/cycle.
//   Counters: increment on s1_valid & adv (acc if pass else rej), regardless of DROP_INVALID;
//     saturate at all-ones; cnt_clr has priority over increment same cycle.
//   Boundaries: y=Y_MAX passes, y=Y_MAX+1 fails; x=0 passes if wall[0]; x=(NCELL<<CELL_SH)-1 is last
//     legal x; wall change while stalled does not alter registered pass.
//   Reset mid-stream discards in-flight points; no output beat for them.
// TESTING
//   Defaults, wall=5'b00100, x=130,y=10,z=-3,p=7 -> 2 cycles later out_valid=1,en=1,x=130,y=10,z=-3(10b),p=7; acc_cnt=1.
//   wall=5'b11011 same point -> out_en=0, out_x/y/z/p=10'h3FF; y=65 and x=320 likewise rejected; rej_cnt=3.
//   Stream 4 points, out_ready=0 for 3 cycles -> in_ready=0, outputs stable, no loss/duplication after release.
//   DROP_INVALID=1, alternate pass/fail -> only passing points emerge, in order; rej_cnt counts failures.
//   CNT_W=4, 20 passing points -> acc_cnt sticks at 15; cnt_clr with concurrent pass -> acc_cnt=0.
//   Assert rst with 2 points in flight -> outputs reset values immediately; no stale beat after release.

Source files
------------

// File: rtl/point_clip_pipe.sv
// Two-stage validity filter for projected maze points: classify in stage 1, narrow/mark in stage 2.
// Valid/ready backpressure stalls both stages together; counters track accepted and rejected points.
module point_clip_pipe #(
    parameter int IN_W         = 12,
    parameter int OUT_W        = 10,
    parameter int P_W          = 10,
    parameter int CELL_SH      = 6,
    parameter int NCELL        = 5,
    parameter int Y_MAX        = 64,
    parameter bit DROP_INVALID = 1'b0,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCELL-1:0]        wall,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_x,
    input  logic signed [IN_W-1:0]  in_y,
    input  logic signed [IN_W-1:0]  in_z,
    input  logic [P_W-1:0]          in_p,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_en,
    output logic signed [OUT_W-1:0] out_x,
    output logic signed [OUT_W-1:0] out_y,
    output logic signed [OUT_W-1:0] out_z,
    output logic [P_W-1:0]          out_p,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        acc_cnt,
    output logic [CNT_W-1:0]        rej_cnt
);

    localparam int CIDX_W = IN_W - 1 - CELL_SH;
    localparam logic signed [IN_W-1:0] Y_LIM = IN_W'(Y_MAX);

    logic              adv;
    logic [CIDX_W-1:0] cidx;
    logic              wall_hit;
    logic              in_pass;
    logic              cnt_inc;

    logic              s1_valid;
    logic              s1_pass;
    logic [OUT_W-1:0]  s1_x;
    logic [OUT_W-1:0]  s1_y;
    logic [OUT_W-1:0]  s1_z;
    logic [P_W-1:0]    s1_p;

    function automatic logic [OUT_W-1:0] narrow(input logic [IN_W-1:0] c);
        return {c[IN_W-1], c[OUT_W-2:0]};
    endfunction

    // The middle bits of z are dropped by narrowing and never inspected.
    generate
        if (IN_W > OUT_W) begin : g_z_mid
            logic unused_z_mid;
            assign unused_z_mid = ^in_z[IN_W-2:OUT_W-1];
        end
    endgenerate

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign cidx     = in_x[IN_W-2:CELL_SH];
    assign cnt_inc  = s1_valid && adv;

    // Compare against each legal index so an out-of-range cidx never indexes wall.
    always_comb begin
        wall_hit = 1'b0;
        for (int i = 0; i < NCELL; i++) begin
            if (int'(cidx) == i) wall_hit = wall[i];
        end
    end

    assign in_pass = !in_y[IN_W-1] && (in_y <= Y_LIM) && !in_x[IN_W-1]
                     && (int'(cidx) < NCELL) && wall_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_pass  <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_z     <= '0;
            s1_p     <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_pass  <= in_valid && in_pass;
            if (in_valid) begin
                s1_x <= narrow(in_x);
                s1_y <= narrow(in_y);
                s1_z <= narrow(in_z);
                s1_p <= in_p;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_en    <= 1'b0;
            out_x     <= '1;
            out_y     <= '1;
            out_z     <= '1;
            out_p     <= '1;
        end else if (adv) begin
            out_valid <= s1_valid && (s1_pass || !DROP_INVALID);
            if (s1_valid && s1_pass) begin
                out_en <= 1'b1;
                out_x  <= s1_x;
                out_y  <= s1_y;
                out_z  <= s1_z;
                out_p  <= s1_p;
            end else begin
                out_en <= 1'b0;
                out_x  <= '1;
                out_y  <= '1;
                out_z  <= '1;
                out_p  <= '1;
            end
        end
    end

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt <= '0;
            rej_cnt <= '0;
        end else if (cnt_clr) begin
            acc_cnt <= '0;
            rej_cnt <= '0;
        end else if (cnt_inc) begin
            if (s1_pass && (acc_cnt != '1)) acc_cnt <= acc_cnt + CNT_W'(1);
            if (!s1_pass && (rej_cnt != '1)) rej_cnt <= rej_cnt + CNT_W'(1);
        end
    end

endmodule
